frontend_ctrl: RTL and testbench

//  Sequences the front-end stages (fetch, align, decode) ahead of Sched.
//  - Generates the per-stage flush and stall for IA/ID.
//  - Issues fetch redirects, including the boot redirect to RESET_PC.
//  - Halts fetch once an excepting instruction has been handed to Sched, until the backend redirects.
//  - Counts backpressure stall cycles for performance logging.

---
 rtl/frontend_ctrl_if.sv | 34 +++
 rtl/frontend_ctrl.sv | 94 +++++++++
 tb/tb_frontend_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/frontend_ctrl_if.sv
// Bundle of front-end control signals between the backend/Sched side and frontend_ctrl.
// Redirect is a valid-only strobe with no ready. Sched accepts the ID instruction in any cycle where it does not assert i_sched_stall.
interface frontend_ctrl_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 i_redirect_valid;
  logic [PC_WIDTH-1:0]  i_redirect_pc;
  logic                 i_sched_stall;
  logic                 i_id_except_valid;
  logic                 i_stall_cnt_clr;

  logic                 o_flush;
  logic                 o_stall;
  logic                 o_fetch_hold;
  logic                 o_redirect_valid;
  logic [PC_WIDTH-1:0]  o_redirect_pc;
  logic [1:0]           o_state;
  logic [CNT_WIDTH-1:0] o_stall_cnt;

  modport master (
    output i_redirect_valid, i_redirect_pc, i_sched_stall,
           i_id_except_valid, i_stall_cnt_clr,
    input  o_flush, o_stall, o_fetch_hold, o_redirect_valid,
           o_redirect_pc, o_state, o_stall_cnt
  );

  modport slave (
    input  i_redirect_valid, i_redirect_pc, i_sched_stall,
           i_id_except_valid, i_stall_cnt_clr,
    output o_flush, o_stall, o_fetch_hold, o_redirect_valid,
           o_redirect_pc, o_state, o_stall_cnt
  );
endinterface

// File: rtl/frontend_ctrl.sv
// Front-end sequencer: per-stage flush/stall for IA/ID, fetch redirects (incl. boot),
// fetch hold after an accepted exception, and a saturating backpressure stall counter.
module frontend_ctrl #(
  parameter int                    PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC     = 32'h8000_0000,
  parameter int                    FLUSH_CYCLES = 2,
  parameter int                    CNT_WIDTH    = 32
) (
  input logic           i_clk,
  input logic           i_rst,
  frontend_ctrl_if.slave fe
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // FLUSH_CYCLES must lie in 1..15 to fit the 4-bit flush counter.
  localparam logic [3:0]           FLUSH_CNT = 4'(FLUSH_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic in_flush;
  logic stall_w;

  assign in_flush = (state_q == ST_FLUSH);
  assign stall_w  = !i_rst && !in_flush && fe.i_sched_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_FLUSH;
      cnt_q       <= FLUSH_CNT;
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state: a redirect wins over everything, including a same-cycle exception.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    if (fe.i_redirect_valid) begin
      state_d = ST_FLUSH;
      cnt_d   = FLUSH_CNT;
      pc_d    = fe.i_redirect_pc;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          if (cnt_q > 4'd1) cnt_d = cnt_q - 4'd1;
          else              state_d = ST_RUN;
        end
        ST_RUN: begin
          if (fe.i_id_except_valid && !fe.i_sched_stall) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          state_d = ST_DRAIN;
        end
        default: begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_CNT;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (fe.i_stall_cnt_clr)                    stall_cnt_d = '0;
    else if (stall_w && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  // Outputs are forced to their reset-time values while i_rst is high.
  assign fe.o_flush          = i_rst || in_flush;
  assign fe.o_redirect_valid = !i_rst && in_flush && (cnt_q == FLUSH_CNT);
  assign fe.o_redirect_pc    = pc_q;
  assign fe.o_stall          = stall_w;
  assign fe.o_fetch_hold     = !i_rst && (state_q == ST_DRAIN);
  assign fe.o_state          = state_q;
  assign fe.o_stall_cnt      = i_rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_frontend_ctrl.sv
// Bench for frontend_ctrl: directed vector table for the multi-cycle cases, then random
// stimulus against a behavioural model of the sequencing rules.
module tb_frontend_ctrl;
  localparam int          FC       = 2;
  localparam int          CW       = 4;
  localparam logic [31:0] RST_PC   = 32'h8000_0000;
  localparam int          W        = 42;
  localparam int          CNT_SAT  = 15;

  logic clk;
  logic rst;

  frontend_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(CW)) fe_if ();

  frontend_ctrl #(
    .PC_WIDTH(32), .RESET_PC(RST_PC), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .fe   (fe_if)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst                      = 1'b1;
    fe_if.i_redirect_valid   = 1'b0;
    fe_if.i_redirect_pc      = '0;
    fe_if.i_sched_stall      = 1'b0;
    fe_if.i_id_except_valid  = 1'b0;
    fe_if.i_stall_cnt_clr    = 1'b0;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // {flush, strobe, stall, hold, state[1:0], stall_cnt[3:0], pc[31:0]}
  function automatic logic [W-1:0] pack(logic fl, logic sb, logic st, logic hd,
                                        logic [1:0] s, logic [3:0] c, logic [31:0] pc);
    return {fl, sb, st, hd, s, c, pc};
  endfunction

  function automatic logic [W-1:0] mask(logic [W-1:0] v, logic chk_sp);
    logic [W-1:0] r;
    r = v;
    if (!chk_sp) begin
      r[37:36] = 2'b00;
      r[31:0]  = 32'h0;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(logic r, logic rv, logic [31:0] rpc, logic ss, logic exc, logic clr);
    @(posedge clk);
    #1;
    rst                     = r;
    fe_if.i_redirect_valid  = rv;
    fe_if.i_redirect_pc     = rpc;
    fe_if.i_sched_stall     = ss;
    fe_if.i_id_except_valid = exc;
    fe_if.i_stall_cnt_clr   = clr;
  endtask

  task automatic check_cycle(string name, logic [W-1:0] expv, logic chk_sp);
    logic [W-1:0] got;
    logic [W-1:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    got = pack(fe_if.o_flush, fe_if.o_redirect_valid, fe_if.o_stall, fe_if.o_fetch_hold,
               fe_if.o_state, fe_if.o_stall_cnt, fe_if.o_redirect_pc);
    e = exp_q.pop_front();
    n_cmp++;
    if (mask(got, chk_sp) !== mask(e, chk_sp)) begin
      n_fail++;
      $display("FAIL %s @%0t: got fl/sb/st/hd=%b%b%b%b state=%0d cnt=%0d pc=%h, want fl/sb/st/hd=%b%b%b%b state=%0d cnt=%0d pc=%h (state/pc checked=%0b)",
               name, $time, got[41], got[40], got[39], got[38], got[37:36], got[35:32], got[31:0],
               e[41], e[40], e[39], e[38], e[37:36], e[35:32], e[31:0], chk_sp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, rv;
    logic [31:0] rpc;
    logic        ss, exc, clr;
    logic [W-1:0] expv;
    logic        chk_sp;
    string       name;
  } vec_t;

  vec_t tbl[64];
  int   n_vec = 0;

  task automatic add(logic r, logic rv, logic [31:0] rpc, logic ss, logic exc, logic clr,
                     logic fl, logic sb, logic st, logic hd, logic [1:0] s, int c,
                     logic [31:0] pc, logic chk_sp, string name);
    tbl[n_vec].rst    = r;
    tbl[n_vec].rv     = rv;
    tbl[n_vec].rpc    = rpc;
    tbl[n_vec].ss     = ss;
    tbl[n_vec].exc    = exc;
    tbl[n_vec].clr    = clr;
    tbl[n_vec].expv   = pack(fl, sb, st, hd, s, 4'(c), pc);
    tbl[n_vec].chk_sp = chk_sp;
    tbl[n_vec].name   = name;
    n_vec++;
  endtask

  task automatic fill_table();
    // reset held 3 cycles, boot strobe, 2-cycle flush
    add(1,0,0,1,0,0, 1,0,0,0, 1, 0, RST_PC,       0, "rst_c0");
    add(1,0,0,1,0,0, 1,0,0,0, 1, 0, RST_PC,       1, "rst_c1");
    add(1,0,0,0,1,0, 1,0,0,0, 1, 0, RST_PC,       1, "rst_c2");
    add(0,0,0,0,0,0, 1,1,0,0, 1, 0, RST_PC,       1, "boot_strobe");
    add(0,0,0,0,0,0, 1,0,0,0, 1, 0, RST_PC,       1, "boot_flush2");
    add(0,0,0,0,0,0, 0,0,0,0, 0, 0, RST_PC,       1, "boot_run");
    // redirect from RUN, flush overrides sched stall
    add(0,1,32'h0000_1234,1,0,0, 0,0,1,0, 0, 0, RST_PC,  1, "redir_req");
    add(0,0,0,1,0,0, 1,1,0,0, 1, 1, 32'h0000_1234,       1, "redir_strobe");
    add(0,0,0,1,0,0, 1,0,0,0, 1, 1, 32'h0000_1234,       1, "redir_flush2");
    add(0,0,0,0,0,0, 0,0,0,0, 0, 1, 32'h0000_1234,       1, "redir_run");
    // back-to-back redirects restart the flush
    add(0,1,32'h0000_AAAA,0,0,0, 0,0,0,0, 0, 1, 32'h0000_1234, 1, "redirA_req");
    add(0,1,32'h0000_BBBB,0,0,0, 1,1,0,0, 1, 1, 32'h0000_AAAA, 1, "redirA_strobe");
    add(0,0,0,0,0,0, 1,1,0,0, 1, 1, 32'h0000_BBBB,       1, "redirB_strobe");
    add(0,0,0,0,0,0, 1,0,0,0, 1, 1, 32'h0000_BBBB,       1, "redirB_flush3");
    // exception held while Sched stalls, accepted once stall drops
    add(0,0,0,1,1,0, 0,0,1,0, 0, 1, 32'h0000_BBBB,       1, "exc_stall1");
    add(0,0,0,1,1,0, 0,0,1,0, 0, 2, 32'h0000_BBBB,       1, "exc_stall2");
    add(0,0,0,0,1,0, 0,0,0,0, 0, 3, 32'h0000_BBBB,       1, "exc_accept");
    add(0,0,0,1,0,0, 0,0,1,1, 2, 3, 32'h0000_BBBB,       1, "drain_hold");
    add(0,0,0,0,1,0, 0,0,0,1, 2, 4, 32'h0000_BBBB,       1, "drain_ignore_exc");
    add(0,1,32'h0000_2000,0,0,0, 0,0,0,1, 2, 4, 32'h0000_BBBB, 1, "drain_redir_req");
    add(0,0,0,0,0,0, 1,1,0,0, 1, 4, 32'h0000_2000,       1, "drain_exit");
    add(0,0,0,0,0,0, 1,0,0,0, 1, 4, 32'h0000_2000,       1, "drain_exit_fl2");
    // same-cycle redirect and unstalled exception: redirect wins
    add(0,1,32'h0000_3000,0,1,0, 0,0,0,0, 0, 4, 32'h0000_2000, 1, "race_req");
    add(0,0,0,0,1,0, 1,1,0,0, 1, 4, 32'h0000_3000,       1, "race_flush");
    add(0,0,0,0,1,0, 1,0,0,0, 1, 4, 32'h0000_3000,       1, "race_flush2");
    add(0,0,0,0,0,0, 0,0,0,0, 0, 4, 32'h0000_3000,       1, "race_run");
    // 20 stalled RUN cycles saturate the 4-bit counter
    for (int i = 0; i < 20; i++)
      add(0,0,0,1,0,0, 0,0,1,0, 0, (4 + i > CNT_SAT) ? CNT_SAT : 4 + i, 32'h0000_3000, 1, "stall_sat");
    add(0,0,0,1,0,1, 0,0,1,0, 0, 15, 32'h0000_3000,      1, "clr_req");
    add(0,0,0,1,0,0, 0,0,1,0, 0, 0,  32'h0000_3000,      1, "clr_zero");
    add(0,0,0,0,0,0, 0,0,0,0, 0, 1,  32'h0000_3000,      1, "clr_one");
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_flush_left;
  bit          m_halted;
  logic [31:0] m_pc;
  int          m_cnt;

  function automatic logic [W-1:0] model_out(logic r, logic ss);
    bit flushing;
    logic [1:0] s;
    if (r) return pack(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 32'h0);
    flushing = (m_flush_left > 0);
    s = flushing ? 2'd1 : (m_halted ? 2'd2 : 2'd0);
    return pack(flushing, m_flush_left == FC, !flushing && ss, m_halted && !flushing,
                s, 4'(m_cnt), m_pc);
  endfunction

  task automatic model_step(logic r, logic rv, logic [31:0] rpc, logic ss, logic exc, logic clr);
    bit flushing;
    if (r) begin
      m_flush_left = FC;
      m_halted     = 0;
      m_pc         = RST_PC;
      m_cnt        = 0;
      return;
    end
    flushing = (m_flush_left > 0);
    if (clr)                    m_cnt = 0;
    else if (!flushing && ss)   m_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
    if (rv) begin
      m_flush_left = FC;
      m_halted     = 0;
      m_pc         = rpc;
    end else if (flushing) begin
      m_flush_left = m_flush_left - 1;
    end else if (!m_halted && exc && !ss) begin
      m_halted = 1;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic        r, rv, ss, exc, clr;
    logic [31:0] rpc;
    fill_table();
    for (int i = 0; i < n_vec; i++) begin
      drive(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].ss, tbl[i].exc, tbl[i].clr);
      check_cycle(tbl[i].name, tbl[i].expv, tbl[i].chk_sp);
    end

    for (int i = 0; i < 800; i++) begin
      r   = (i < 2) || ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rpc = $urandom;
      ss  = $urandom_range(0, 1) == 1;
      exc = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 31) == 0);
      drive(r, rv, rpc, ss, exc, clr);
      check_cycle("rand", model_out(r, ss), !r);
      model_step(r, rv, rpc, ss, exc, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
